rv32i_mem_arbiter: RTL and testbench

//  Shares one synchronous-read memory port between two requesters: port 0 is the rv32i

---
 rtl/rv32i_mem_arbiter.sv | 137 +++++++++++++
 tb/tb_rv32i_mem_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_mem_arbiter.sv
// Two-port arbiter in front of one synchronous-read memory: core (p0) and DMA/debug (p1).
// Latency: gnt 1 cycle after req, write done +2, read done +READ_LATENCY+2; one transaction in flight.
// Backpressure: a losing or late req waits while busy and is never dropped while held high.
// Optional: MEM_ARB_ROUND_ROBIN_EN selects round-robin tie-break; default is fixed priority to p0.
module rv32i_mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wr_data,
    input  logic              p0_wr_ena,
    output logic              p0_gnt,
    output logic              p0_done,
    output logic [DATA_W-1:0] p0_rd_data,
    input  logic              p1_req,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wr_data,
    input  logic              p1_wr_ena,
    output logic              p1_gnt,
    output logic              p1_done,
    output logic [DATA_W-1:0] p1_rd_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              mem_wr_ena,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              busy
);

    if (READ_LATENCY < 1 || READ_LATENCY > 15) begin : g_bad_latency
        $error("rv32i_mem_arbiter: READ_LATENCY must be in 1..15");
    end

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        cnt;
    logic              win;          // port owning the in-flight transaction
    logic              last_grant;
    logic              arb_win;      // port that would win a capture this cycle
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wr_data;
    logic              lat_wr_ena;

    // Winner selection; a lone requester always wins, ties depend on build
`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_comb begin
        arb_win = p1_req & (~p0_req | ~last_grant);
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        arb_win = p1_req & ~p0_req;
    end
`endif

    // Next-state and handshake pulses decoded from the current state
    always_comb begin
        state_nxt = state;
        p0_gnt    = 1'b0;
        p1_gnt    = 1'b0;
        p0_done   = 1'b0;
        p1_done   = 1'b0;
        case (state)
            S_IDLE: begin
                if (p0_req || p1_req) state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                p0_gnt    = ~win;
                p1_gnt    = win;
                state_nxt = lat_wr_ena ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                if (cnt == 4'd0) state_nxt = S_RESP;
            end
            S_RESP: begin
                p0_done   = ~win;
                p1_done   = win;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Memory side is driven straight from the capture latches
    assign mem_addr    = lat_addr;
    assign mem_wr_data = lat_wr_data;
    assign mem_wr_ena  = (state == S_ISSUE) && lat_wr_ena;
    assign busy        = (state != S_IDLE);

    // State register, request capture, latency counter and read-data return
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= 4'd0;
            win         <= 1'b0;
            last_grant  <= 1'b1;
            lat_addr    <= '0;
            lat_wr_data <= '0;
            lat_wr_ena  <= 1'b0;
            p0_rd_data  <= '0;
            p1_rd_data  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (p0_req || p1_req) begin
                        win         <= arb_win;
                        last_grant  <= arb_win;
                        lat_addr    <= arb_win ? p1_addr    : p0_addr;
                        lat_wr_data <= arb_win ? p1_wr_data : p0_wr_data;
                        lat_wr_ena  <= arb_win ? p1_wr_ena  : p0_wr_ena;
                    end
                end
                S_ISSUE: begin
                    cnt <= 4'(READ_LATENCY - 1);
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        if (win) p1_rd_data <= mem_rd_data;
                        else     p0_rd_data <= mem_rd_data;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Directed bench: three arbiters with READ_LATENCY 1, 2 and 3, each behind a latency-accurate memory model.
// Inputs are driven 1 time unit after the rising edge; outputs are checked at that same point.
// Summary line reports failed and total comparisons.
module tb_rv32i_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst         [3];
    logic        p0_req      [3];
    logic [31:0] p0_addr     [3];
    logic [31:0] p0_wr_data  [3];
    logic        p0_wr_ena   [3];
    logic        p0_gnt      [3];
    logic        p0_done     [3];
    logic [31:0] p0_rd_data  [3];
    logic        p1_req      [3];
    logic [31:0] p1_addr     [3];
    logic [31:0] p1_wr_data  [3];
    logic        p1_wr_ena   [3];
    logic        p1_gnt      [3];
    logic        p1_done     [3];
    logic [31:0] p1_rd_data  [3];
    logic [31:0] mem_addr    [3];
    logic [31:0] mem_wr_data [3];
    logic        mem_wr_ena  [3];
    logic [31:0] mem_rd_data [3];
    logic        busy        [3];

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    // Memory contents: one fixed word at 0x40, an address-derived pattern elsewhere
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a == 32'h40) ? 32'hDEAD_BEEF : (a ^ 32'hA5A5_0000);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [31:0] pipe [3];
        always @(posedge clk) begin
            pipe[0] <= mem_f(mem_addr[g]);
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
        end
        assign mem_rd_data[g] = pipe[g];

        rv32i_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(g + 1)) u_dut (
            .clk         (clk),
            .rst         (rst[g]),
            .p0_req      (p0_req[g]),
            .p0_addr     (p0_addr[g]),
            .p0_wr_data  (p0_wr_data[g]),
            .p0_wr_ena   (p0_wr_ena[g]),
            .p0_gnt      (p0_gnt[g]),
            .p0_done     (p0_done[g]),
            .p0_rd_data  (p0_rd_data[g]),
            .p1_req      (p1_req[g]),
            .p1_addr     (p1_addr[g]),
            .p1_wr_data  (p1_wr_data[g]),
            .p1_wr_ena   (p1_wr_ena[g]),
            .p1_gnt      (p1_gnt[g]),
            .p1_done     (p1_done[g]),
            .p1_rd_data  (p1_rd_data[g]),
            .mem_addr    (mem_addr[g]),
            .mem_wr_data (mem_wr_data[g]),
            .mem_wr_ena  (mem_wr_ena[g]),
            .mem_rd_data (mem_rd_data[g]),
            .busy        (busy[g])
        );
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int d, input int p, input logic [31:0] a,
                       input logic [31:0] wd, input logic we);
        if (p == 0) begin
            p0_req[d] = 1'b1; p0_addr[d] = a; p0_wr_data[d] = wd; p0_wr_ena[d] = we;
        end else begin
            p1_req[d] = 1'b1; p1_addr[d] = a; p1_wr_data[d] = wd; p1_wr_ena[d] = we;
        end
    endtask

    task automatic drop(input int d, input int p);
        if (p == 0) p0_req[d] = 1'b0;
        else        p1_req[d] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          ngr;
        int          gseq [4];
        int          p0d;
        logic        seen_g;
        logic        seen_w;
        logic [31:0] exp_seq [4];

        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1;
            p0_req[d] = 1'b0; p0_addr[d] = '0; p0_wr_data[d] = '0; p0_wr_ena[d] = 1'b0;
            p1_req[d] = 1'b0; p1_addr[d] = '0; p1_wr_data[d] = '0; p1_wr_ena[d] = 1'b0;
        end
        tick();
        tick();
        for (int d = 0; d < 3; d++) begin
            check_eq($sformatf("rst_busy%0d", d),    32'(busy[d]), 32'd0);
            check_eq($sformatf("rst_gnt%0d", d),     32'({p1_gnt[d], p0_gnt[d]}), 32'd0);
            check_eq($sformatf("rst_done%0d", d),    32'({p1_done[d], p0_done[d]}), 32'd0);
            check_eq($sformatf("rst_we%0d", d),      32'(mem_wr_ena[d]), 32'd0);
            check_eq($sformatf("rst_addr%0d", d),    mem_addr[d], 32'd0);
            check_eq($sformatf("rst_wdata%0d", d),   mem_wr_data[d], 32'd0);
            check_eq($sformatf("rst_rd0_%0d", d),    p0_rd_data[d], 32'd0);
            check_eq($sformatf("rst_rd1_%0d", d),    p1_rd_data[d], 32'd0);
            rst[d] = 1'b0;
        end
        tick();

        // 1: single p0 read at 0x40, L=1
        req(0, 0, 32'h40, 32'h0, 1'b0);
        check_eq("t1_gnt_T", 32'(p0_gnt[0]), 32'd0);
        tick();
        check_eq("t1_gnt_T1", 32'(p0_gnt[0]), 32'd1);
        check_eq("t1_busy_T1", 32'(busy[0]), 32'd1);
        drop(0, 0);
        tick();
        check_eq("t1_done_T2", 32'(p0_done[0]), 32'd0);
        tick();
        check_eq("t1_done_T3", 32'(p0_done[0]), 32'd1);
        check_eq("t1_rd_data", p0_rd_data[0], 32'hDEAD_BEEF);
        check_eq("t1_p1_done", 32'(p1_done[0]), 32'd0);
        tick();
        check_eq("t1_idle", 32'(busy[0]), 32'd0);

        // 2: single p1 write 0x12345678 to 0x80
        req(0, 1, 32'h80, 32'h1234_5678, 1'b1);
        tick();
        check_eq("t2_we_T1", 32'(mem_wr_ena[0]), 32'd1);
        check_eq("t2_addr", mem_addr[0], 32'h80);
        check_eq("t2_wdata", mem_wr_data[0], 32'h1234_5678);
        check_eq("t2_gnt", 32'({p1_gnt[0], p0_gnt[0]}), 32'b10);
        drop(0, 1);
        tick();
        check_eq("t2_we_T2", 32'(mem_wr_ena[0]), 32'd0);
        check_eq("t2_done_T2", 32'(p1_done[0]), 32'd1);
        check_eq("t2_rd1_kept", p1_rd_data[0], 32'd0);
        tick();
        check_eq("t2_idle", 32'(busy[0]), 32'd0);

        // 6: p1 pulses req for one cycle while p0 is busy
        req(0, 0, 32'h40, 32'h0, 1'b0);
        tick();
        check_eq("t6_p0_gnt", 32'(p0_gnt[0]), 32'd1);
        drop(0, 0);
        req(0, 1, 32'h90, 32'h5555_AAAA, 1'b1);
        tick();
        drop(0, 1);
        seen_g = 1'b0; seen_w = 1'b0; p0d = 0;
        for (int i = 0; i < 10; i++) begin
            seen_g |= p1_gnt[0];
            seen_w |= mem_wr_ena[0];
            if (p0_done[0]) p0d++;
            tick();
        end
        check_eq("t6_p1_gnt", 32'(seen_g), 32'd0);
        check_eq("t6_we", 32'(seen_w), 32'd0);
        check_eq("t6_p0_done_cnt", 32'(p0d), 32'd1);

        // 3: both ports read continuously, L=2
        req(1, 0, 32'h100, 32'h0, 1'b0);
        req(1, 1, 32'h200, 32'h0, 1'b0);
        ngr = 0;
        for (int i = 0; i < 60 && ngr < 4; i++) begin
            tick();
            if (p0_gnt[1]) begin gseq[ngr] = 0; ngr++; end
            else if (p1_gnt[1]) begin gseq[ngr] = 1; ngr++; end
        end
        drop(1, 0);
        drop(1, 1);
        check_eq("t3_ngrants", 32'(ngr), 32'd4);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_seq = '{32'd0, 32'd1, 32'd0, 32'd1};
`else
        exp_seq = '{32'd0, 32'd0, 32'd0, 32'd0};
`endif
        for (int k = 0; k < 4; k++)
            check_eq($sformatf("t3_grant%0d", k), (k < ngr) ? 32'(gseq[k]) : 32'hFFFF_FFFF, exp_seq[k]);
        for (int i = 0; i < 20 && busy[1]; i++) tick();
        check_eq("t3_idle", 32'(busy[1]), 32'd0);
        check_eq("t3_rd0", p0_rd_data[1], 32'hA5A5_0100);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        check_eq("t3_rd1", p1_rd_data[1], 32'hA5A5_0200);
`else
        check_eq("t3_rd1", p1_rd_data[1], 32'h0);
`endif

        // 4: p0 read L=3, p1 write arrives while busy and waits
        req(2, 0, 32'h44, 32'h0, 1'b0);
        tick();
        check_eq("t4_gnt", 32'(p0_gnt[2]), 32'd1);
        check_eq("t4_addr_T1", mem_addr[2], 32'h44);
        drop(2, 0);
        for (int i = 2; i <= 4; i++) begin
            tick();
            if (i == 2) req(2, 1, 32'h90, 32'hCAFE_F00D, 1'b1);
            check_eq($sformatf("t4_addr_T%0d", i), mem_addr[2], 32'h44);
            check_eq($sformatf("t4_nodone_T%0d", i), 32'(p0_done[2]), 32'd0);
            check_eq($sformatf("t4_p1_quiet_T%0d", i), 32'({p1_gnt[2], p1_done[2]}), 32'd0);
            check_eq($sformatf("t4_we_T%0d", i), 32'(mem_wr_ena[2]), 32'd0);
        end
        tick();
        check_eq("t4_done_T5", 32'(p0_done[2]), 32'd1);
        check_eq("t4_rd", p0_rd_data[2], 32'hA5A5_0044);
        check_eq("t4_p1_gnt_T5", 32'(p1_gnt[2]), 32'd0);
        tick();
        check_eq("t4_idle_T6", 32'(busy[2]), 32'd0);
        tick();
        check_eq("t4_p1_gnt_T7", 32'(p1_gnt[2]), 32'd1);
        check_eq("t4_p1_we_T7", 32'(mem_wr_ena[2]), 32'd1);
        check_eq("t4_p1_addr", mem_addr[2], 32'h90);
        drop(2, 1);
        tick();
        check_eq("t4_p1_done_T8", 32'(p1_done[2]), 32'd1);
        tick();

        // 5: reset while waiting for read data
        req(2, 0, 32'h48, 32'h0, 1'b0);
        tick();
        check_eq("t5_gnt", 32'(p0_gnt[2]), 32'd1);
        drop(2, 0);
        tick();
        check_eq("t5_busy_wait", 32'(busy[2]), 32'd1);
        rst[2] = 1'b1;
        tick();
        rst[2] = 1'b0;
        check_eq("t5_busy_rst", 32'(busy[2]), 32'd0);
        check_eq("t5_rd_rst", p0_rd_data[2], 32'd0);
        p0d = 0; seen_w = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (p0_done[2]) p0d++;
            seen_w |= mem_wr_ena[2];
            tick();
        end
        check_eq("t5_no_done", 32'(p0d), 32'd0);
        check_eq("t5_no_we", 32'(seen_w), 32'd0);
        req(2, 0, 32'h4C, 32'h0, 1'b0);
        tick();
        check_eq("t5_regnt", 32'(p0_gnt[2]), 32'd1);
        drop(2, 0);
        tick(); tick(); tick();
        check_eq("t5_nodone_T4", 32'(p0_done[2]), 32'd0);
        tick();
        check_eq("t5_done_T5", 32'(p0_done[2]), 32'd1);
        check_eq("t5_rd", p0_rd_data[2], 32'hA5A5_004C);
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
